// File: rtl/mpmc10_wr_cmd_seq.sv
// mpmc10_wr_cmd_seq
// Write-command sequencer for the mpmc10 multi-port memory controller.
// Takes one granted write request at a time from the port arbiter and drives
// the MIG user-interface command channel and write-data channel. Each channel
// is handshaked on its own, so the MIG may accept the command and the data
// beat in either order or in the same cycle. Once both are accepted, a
// one-cycle completion pulse goes back to the arbiter.
//
// Ports:
//   clk, rstn         controller clock (MIG ui_clk), asynchronous active-low reset
//   calib_done        MIG calibration complete; requests are held off while low
//   req               write request from the arbiter, held until req_ack
//   req_adr           beat address of the request
//   req_dat           write data
//   req_sel           byte enables, active-high
//   req_ack           one-cycle pulse: request captured
//   done              one-cycle pulse: command and data both accepted
//   busy              high from capture through the done cycle
//   timeout           one-cycle stall-flag pulse
//   app_en            MIG command valid
//   app_cmd           MIG command (always write)
//   app_addr          MIG address
//   app_rdy           MIG command-channel ready
//   app_wdf_wren      MIG write-data valid
//   app_wdf_data      MIG write data
//   app_wdf_mask      MIG byte mask, active-high = byte not written
//   app_wdf_end       last beat of burst (single beat per command)
//   app_wdf_rdy       MIG write-data ready

module mpmc10_wr_cmd_seq #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 29,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    calib_done,
  input  logic                    req,
  input  logic [ADDR_WIDTH-1:0]   req_adr,
  input  logic [DATA_WIDTH-1:0]   req_dat,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  output logic                    req_ack,
  output logic                    done,
  output logic                    busy,
  output logic                    timeout,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  input  logic                    app_rdy,
  output logic                    app_wdf_wren,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_end,
  input  logic                    app_wdf_rdy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // BL8 alignment: the low three address bits are forced to zero on capture.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(7);
  localparam logic [15:0]           TO_LIMIT   = 16'(TIMEOUT);
  localparam logic [15:0]           TO_PULSE   = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        capture;
  logic        cmd_pend;
  logic        dat_pend;
  logic        cmd_hs;
  logic        dat_hs;
  logic [15:0] stall_cnt;

  // The valids are the pending flags themselves, so a handshake is simply a
  // pending flag meeting its ready.
  assign cmd_hs = cmd_pend & app_rdy;
  assign dat_hs = dat_pend & app_wdf_rdy;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. ISSUE exits only once each channel is either already
  // accepted or being accepted at this edge, which covers both handshakes
  // landing together.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req && calib_done) begin
          state_nxt = ISSUE;
          capture   = 1'b1;
        end
      end
      ISSUE: begin
        if ((!cmd_pend || cmd_hs) && (!dat_pend || dat_hs)) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pending flags, capture acknowledge and stall counter. The counter starts
  // from zero on every capture and holds at TIMEOUT, so the stall flag can
  // fire only once per transaction.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_pend  <= 1'b0;
      dat_pend  <= 1'b0;
      req_ack   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      req_ack <= capture;
      if (capture) begin
        cmd_pend  <= 1'b1;
        dat_pend  <= 1'b1;
        stall_cnt <= '0;
      end else begin
        if (cmd_hs) begin
          cmd_pend <= 1'b0;
        end
        if (dat_hs) begin
          dat_pend <= 1'b0;
        end
        if (state == ISSUE && stall_cnt != TO_LIMIT) begin
          stall_cnt <= stall_cnt + 16'd1;
        end
      end
    end
  end

  // Captured command and data. These load only on capture, so they stay
  // stable for as long as either channel is pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      app_addr     <= '0;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
    end else if (capture) begin
      app_addr     <= req_adr & ALIGN_MASK;
      app_wdf_data <= req_dat;
      app_wdf_mask <= ~req_sel;
    end
  end

  assign app_cmd      = 3'b000;
  assign app_en       = cmd_pend;
  assign app_wdf_wren = dat_pend;
  assign app_wdf_end  = dat_pend;
  assign busy         = (state != IDLE);
  assign done         = (state == ACK);

  // In the n-th ISSUE cycle the counter reads n-1, so this fires during the
  // TIMEOUT-th ISSUE cycle. The counter then saturates past this value.
  assign timeout      = (state == ISSUE) && (stall_cnt == TO_PULSE);

endmodule

// File: tb/tb_mpmc10_wr_cmd_seq.sv
// tb_mpmc10_wr_cmd_seq
// Directed self-checking bench for mpmc10_wr_cmd_seq with TIMEOUT = 8.
// Inputs are driven 1 time unit after a rising edge and outputs are checked
// at the same point, so the cycle after edge k is observed as "cycle k+1".

module tb_mpmc10_wr_cmd_seq;

  localparam int DW = 128;
  localparam int AW = 29;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          calib_done;
  logic          req;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic [SW-1:0] req_sel;
  logic          req_ack;
  logic          done;
  logic          busy;
  logic          timeout;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_rdy;
  logic          app_wdf_wren;
  logic [DW-1:0] app_wdf_data;
  logic [SW-1:0] app_wdf_mask;
  logic          app_wdf_end;
  logic          app_wdf_rdy;

  int vecCount = 0;
  int errCount = 0;

  mpmc10_wr_cmd_seq #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .calib_done  (calib_done),
    .req         (req),
    .req_adr     (req_adr),
    .req_dat     (req_dat),
    .req_sel     (req_sel),
    .req_ack     (req_ack),
    .done        (done),
    .busy        (busy),
    .timeout     (timeout),
    .app_en      (app_en),
    .app_cmd     (app_cmd),
    .app_addr    (app_addr),
    .app_rdy     (app_rdy),
    .app_wdf_wren(app_wdf_wren),
    .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask),
    .app_wdf_end (app_wdf_end),
    .app_wdf_rdy (app_wdf_rdy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vecCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [SW-1:0] s);
    req     = r;
    req_adr = a;
    req_dat = d;
    req_sel = s;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".req_ack"}, 128'(req_ack), 128'd0);
    checkOutput({tag, ".done"}, 128'(done), 128'd0);
    checkOutput({tag, ".busy"}, 128'(busy), 128'd0);
    checkOutput({tag, ".timeout"}, 128'(timeout), 128'd0);
    checkOutput({tag, ".app_en"}, 128'(app_en), 128'd0);
    checkOutput({tag, ".app_cmd"}, 128'(app_cmd), 128'd0);
    checkOutput({tag, ".app_addr"}, 128'(app_addr), 128'd0);
    checkOutput({tag, ".wren"}, 128'(app_wdf_wren), 128'd0);
    checkOutput({tag, ".wdf_end"}, 128'(app_wdf_end), 128'd0);
    checkOutput({tag, ".wdf_data"}, 128'(app_wdf_data), 128'd0);
    checkOutput({tag, ".wdf_mask"}, 128'(app_wdf_mask), 128'd0);
  endtask

  // Hard stop in case the stimulus sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;
    logic [DW-1:0] d4;
    logic [DW-1:0] d5;
    logic [DW-1:0] d6;
    int            pulses;

    d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    d3 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    d4 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    d5 = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;
    d6 = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF;

    // Reset state
    rstn        = 1'b0;
    calib_done  = 1'b1;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    applyStimulus(1'b0, '0, '0, '0);
    stepCycle();
    stepCycle();
    checkAllZero("reset");
    rstn = 1'b1;
    stepCycle();

    // Both readies high, back-to-back requests
    applyStimulus(1'b1, 29'h1234567, d1, 16'hFFFF);
    stepCycle();
    checkOutput("t1.req_ack", 128'(req_ack), 128'd1);
    checkOutput("t1.app_en", 128'(app_en), 128'd1);
    checkOutput("t1.wren", 128'(app_wdf_wren), 128'd1);
    checkOutput("t1.wdf_end", 128'(app_wdf_end), 128'd1);
    checkOutput("t1.busy", 128'(busy), 128'd1);
    checkOutput("t1.app_addr", 128'(app_addr), 128'h1234560);
    checkOutput("t1.mask", 128'(app_wdf_mask), 128'd0);
    checkOutput("t1.data", 128'(app_wdf_data), 128'(d1));
    checkOutput("t1.app_cmd", 128'(app_cmd), 128'd0);
    applyStimulus(1'b1, 29'h0ABCDEF, d2, 16'hFFFF);
    stepCycle();
    checkOutput("t1.done", 128'(done), 128'd1);
    checkOutput("t1.c2_en", 128'(app_en), 128'd0);
    checkOutput("t1.c2_wren", 128'(app_wdf_wren), 128'd0);
    checkOutput("t1.c2_ack", 128'(req_ack), 128'd0);
    checkOutput("t1.c2_busy", 128'(busy), 128'd1);
    stepCycle();
    checkOutput("t1.c3_busy", 128'(busy), 128'd0);
    checkOutput("t1.c3_done", 128'(done), 128'd0);
    checkOutput("t1.c3_ack", 128'(req_ack), 128'd0);
    stepCycle();
    checkOutput("t1.c4_ack", 128'(req_ack), 128'd1);
    checkOutput("t1.c4_addr", 128'(app_addr), 128'h0ABCDE8);
    checkOutput("t1.c4_data", 128'(app_wdf_data), 128'(d2));
    applyStimulus(1'b0, '0, '0, '0);
    stepCycle();
    checkOutput("t1.c5_done", 128'(done), 128'd1);
    stepCycle();
    checkOutput("t1.c6_busy", 128'(busy), 128'd0);

    // app_rdy low for 5 ISSUE cycles, data channel ready
    app_rdy = 1'b0;
    applyStimulus(1'b1, 29'h0000F0F, d3, 16'hFFFF);
    stepCycle();
    checkOutput("t2.req_ack", 128'(req_ack), 128'd1);
    applyStimulus(1'b0, '0, '0, '0);
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) app_rdy = 1'b1;
      checkOutput($sformatf("t2.en_c%0d", i), 128'(app_en), 128'd1);
      checkOutput($sformatf("t2.wren_c%0d", i), 128'(app_wdf_wren), 128'(i == 1));
      checkOutput($sformatf("t2.done_c%0d", i), 128'(done), 128'd0);
      checkOutput($sformatf("t2.addr_c%0d", i), 128'(app_addr), 128'hF08);
      checkOutput($sformatf("t2.data_c%0d", i), 128'(app_wdf_data), 128'(d3));
      checkOutput($sformatf("t2.tmo_c%0d", i), 128'(timeout), 128'd0);
      stepCycle();
    end
    checkOutput("t2.done", 128'(done), 128'd1);
    checkOutput("t2.en_after", 128'(app_en), 128'd0);
    stepCycle();

    // app_wdf_rdy low for 4 ISSUE cycles, command channel ready
    app_wdf_rdy = 1'b0;
    applyStimulus(1'b1, 29'h0100007, d4, 16'h00FF);
    stepCycle();
    checkOutput("t3.req_ack", 128'(req_ack), 128'd1);
    checkOutput("t3.mask", 128'(app_wdf_mask), 128'hFF00);
    applyStimulus(1'b0, '0, '0, '0);
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) app_wdf_rdy = 1'b1;
      checkOutput($sformatf("t3.en_c%0d", i), 128'(app_en), 128'(i == 1));
      checkOutput($sformatf("t3.wren_c%0d", i), 128'(app_wdf_wren), 128'd1);
      checkOutput($sformatf("t3.end_c%0d", i), 128'(app_wdf_end), 128'd1);
      checkOutput($sformatf("t3.done_c%0d", i), 128'(done), 128'd0);
      checkOutput($sformatf("t3.data_c%0d", i), 128'(app_wdf_data), 128'(d4));
      stepCycle();
    end
    checkOutput("t3.done", 128'(done), 128'd1);
    checkOutput("t3.wren_after", 128'(app_wdf_wren), 128'd0);
    stepCycle();

    // Calibration not done: request held off
    calib_done = 1'b0;
    applyStimulus(1'b1, 29'h0000040, d5, 16'hFFFF);
    for (int i = 1; i <= 10; i++) begin
      stepCycle();
      checkOutput($sformatf("t4.ack_c%0d", i), 128'(req_ack), 128'd0);
      checkOutput($sformatf("t4.en_c%0d", i), 128'(app_en), 128'd0);
      checkOutput($sformatf("t4.busy_c%0d", i), 128'(busy), 128'd0);
    end
    calib_done = 1'b1;
    stepCycle();
    checkOutput("t4.req_ack", 128'(req_ack), 128'd1);
    checkOutput("t4.app_en", 128'(app_en), 128'd1);
    checkOutput("t4.addr", 128'(app_addr), 128'h40);
    applyStimulus(1'b0, '0, '0, '0);
    stepCycle();
    checkOutput("t4.done", 128'(done), 128'd1);
    stepCycle();

    // Stall timeout with app_rdy low for 20 ISSUE cycles
    app_rdy = 1'b0;
    pulses  = 0;
    applyStimulus(1'b1, 29'h0000123, d6, 16'hFFFF);
    stepCycle();
    applyStimulus(1'b0, '0, '0, '0);
    for (int n = 1; n <= 21; n++) begin
      if (n == 21) app_rdy = 1'b1;
      if (timeout) pulses++;
      checkOutput($sformatf("t5.tmo_c%0d", n), 128'(timeout), 128'(n == 8));
      checkOutput($sformatf("t5.en_c%0d", n), 128'(app_en), 128'd1);
      checkOutput($sformatf("t5.done_c%0d", n), 128'(done), 128'd0);
      stepCycle();
    end
    checkOutput("t5.pulses", 128'(pulses), 128'd1);
    checkOutput("t5.done", 128'(done), 128'd1);
    checkOutput("t5.tmo_ack", 128'(timeout), 128'd0);
    stepCycle();

    // Asynchronous reset in the middle of ISSUE
    app_rdy     = 1'b0;
    app_wdf_rdy = 1'b0;
    applyStimulus(1'b1, 29'h0000777, d1, 16'h0F0F);
    stepCycle();
    applyStimulus(1'b0, '0, '0, '0);
    stepCycle();
    checkOutput("t6.pre_en", 128'(app_en), 128'd1);
    #2;
    rstn = 1'b0;
    #1;
    checkAllZero("t6.async");
    stepCycle();
    stepCycle();
    rstn        = 1'b1;
    app_rdy     = 1'b1;
    app_wdf_rdy = 1'b1;
    stepCycle();
    checkOutput("t6.post_done", 128'(done), 128'd0);
    checkOutput("t6.post_busy", 128'(busy), 128'd0);
    applyStimulus(1'b1, 29'h1FFFFFFF, d2, 16'h00FF);
    stepCycle();
    checkOutput("t6.req_ack", 128'(req_ack), 128'd1);
    checkOutput("t6.addr", 128'(app_addr), 128'h1FFFFFF8);
    checkOutput("t6.mask", 128'(app_wdf_mask), 128'hFF00);
    applyStimulus(1'b0, '0, '0, '0);
    stepCycle();
    checkOutput("t6.done", 128'(done), 128'd1);
    stepCycle();
    checkOutput("t6.idle", 128'(busy), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
